// File: rtl/vvp_pkg.sv
// vvp_pkg: shared definitions for the vvp bit-serial sequencer.
//   - vvp mode encodings driven on the vvp mode input
//   - sequencer state encoding
//   - precision clamping helper (0 -> 1, above max -> max)
package vvp_pkg;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_POS  = 2'b01;
  localparam logic [1:0] MODE_PM   = 2'b10;
  localparam logic [1:0] MODE_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Legal precision range is 1..maxp.
  function automatic int unsigned clamp_prec(input int unsigned p,
                                             input int unsigned maxp);
    if (p == 0)    return 1;
    if (p > maxp)  return maxp;
    return p;
  endfunction

endpackage

// File: rtl/vvp_seq_tag_pipe.sv
// vvp_seq_tag_pipe: LAT-deep delay line of {valid, shift, last} tags that
// travels alongside the vvp pipeline, so each returned sum meets the
// significance it was issued with. LAT=0 is a combinational pass-through.
// Ports:
//   clk, rst        clock, synchronous active-high clear of all entries
//   i_vld/i_shift/i_last   tag pushed on every issue
//   o_vld/o_shift/o_last   tag aligned with the vvp result of this cycle
module vvp_seq_tag_pipe #(
  parameter int LAT = 0,
  parameter int SW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [SW-1:0] i_shift,
  input  logic          i_last,
  output logic          o_vld,
  output logic [SW-1:0] o_shift,
  output logic          o_last
);

  generate
    if (LAT == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_vld    = i_vld;
      assign o_shift  = i_shift;
      assign o_last   = i_last;
    end else begin : g_pipe
      logic [LAT-1:0]         r_vld;
      logic [LAT-1:0][SW-1:0] r_shift;
      logic [LAT-1:0]         r_last;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld   <= '0;
          r_shift <= '0;
          r_last  <= '0;
        end else begin
          r_vld[0]   <= i_vld;
          r_shift[0] <= i_shift;
          r_last[0]  <= i_last;
          for (int k = 1; k < LAT; k++) begin
            r_vld[k]   <= r_vld[k-1];
            r_shift[k] <= r_shift[k-1];
            r_last[k]  <= r_last[k-1];
          end
        end
      end

      assign o_vld   = r_vld[LAT-1];
      assign o_shift = r_shift[LAT-1];
      assign o_last  = r_last[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/vvp_seq.sv
// vvp_seq: bit-serial sequencer for the vvp dot-product datapath.
// Walks every (weight-plane i, data-plane j) pair, one per cycle, selects
// the vvp mode (negating when exactly one operand plane is a signed MSB),
// and accumulates the returned sums shifted by i+j.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin a job (IDLE only)
//   wprec/dprec          precisions, clamped to 1..MAXP at start
//   wsigned/dsigned      operands are two's complement
//   busy                 not IDLE
//   waddr/daddr          bit-plane indices to plane storage
//   mode                 vvp mode
//   s_in                 vvp result, LAT cycles after issue
//   acc_out/out_valid/out_ready   result handshake
module vvp_seq
  import vvp_pkg::*;
#(
  parameter  int N    = 64,
  parameter  int MAXP = 8,
  parameter  int LAT  = 0,
  parameter  int ACCW = $clog2(N) + 2 + 2*MAXP,
  localparam int A    = $clog2(N),
  localparam int PB   = $clog2(MAXP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PB:0]            wprec,
  input  logic [PB:0]            dprec,
  input  logic                   wsigned,
  input  logic                   dsigned,
  output logic                   busy,
  output logic [PB-1:0]          waddr,
  output logic [PB-1:0]          daddr,
  output logic [1:0]             mode,
  input  logic signed [A+1:0]    s_in,
  output logic signed [ACCW-1:0] acc_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  state_t                r_state, w_next;
  logic [PB-1:0]         r_i, r_j;
  // Last plane index (precision - 1) rather than precision, so the
  // wrap/MSB compares are plain equality on counter-width values.
  logic [PB-1:0]         r_wlast, r_dlast;
  logic                  r_ws, r_ds;
  logic signed [ACCW-1:0] r_acc;

  logic                  w_issue, w_jwrap, w_last_pair, w_negw, w_negd;
  logic [PB:0]           w_shift;
  logic                  w_pv, w_pl;
  logic [PB:0]           w_ps;
  logic signed [ACCW-1:0] w_sext, w_term;

  assign w_issue     = (r_state == ISSUE);
  assign w_jwrap     = (r_j == r_dlast);
  assign w_last_pair = w_jwrap && (r_i == r_wlast);
  assign w_negw      = r_ws && (r_i == r_wlast);
  assign w_negd      = r_ds && w_jwrap;
  assign w_shift     = {1'b0, r_i} + {1'b0, r_j};

  // Counters rest at 0 outside ISSUE, so the addresses need no gating.
  assign waddr     = r_i;
  assign daddr     = r_j;
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;

  vvp_seq_tag_pipe #(.LAT(LAT), .SW(PB+1)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (w_issue),
    .i_shift (w_shift),
    .i_last  (w_last_pair),
    .o_vld   (w_pv),
    .o_shift (w_ps),
    .o_last  (w_pl)
  );

  assign w_sext = {{(ACCW-A-2){s_in[A+1]}}, s_in};
  assign w_term = w_sext <<< w_ps;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    mode   = MODE_ZERO;
    case (r_state)
      IDLE:  if (start) w_next = ISSUE;
      ISSUE: begin
        mode = (w_negw ^ w_negd) ? MODE_NEG : MODE_POS;
        // With no vvp latency the last sum accumulates on this same edge.
        if (w_last_pair) w_next = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: if (w_pv && w_pl) w_next = DONE;
      DONE:  if (out_ready)    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= '0;
      r_j     <= '0;
      r_wlast <= '0;
      r_dlast <= '0;
      r_ws    <= 1'b0;
      r_ds    <= 1'b0;
      r_acc   <= '0;
    end else if (r_state == IDLE && start) begin
      r_wlast <= PB'(clamp_prec(32'(wprec), MAXP) - 1);
      r_dlast <= PB'(clamp_prec(32'(dprec), MAXP) - 1);
      r_ws    <= wsigned;
      r_ds    <= dsigned;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
    end else begin
      if (w_issue) begin
        if (w_jwrap) begin
          r_j <= '0;
          r_i <= (r_i == r_wlast) ? '0 : r_i + PB'(1);
        end else begin
          r_j <= r_j + PB'(1);
        end
      end
      if (w_pv) r_acc <= r_acc + w_term;
    end
  end

endmodule

// File: tb/tb_vvp_seq.sv
// tb_vvp_seq: drives a LAT=0 and a LAT=3 sequencer with identical stimulus.
// Each is wrapped by a behavioural vvp (popcount over bit-planes) and
// checked every cycle against a job-level model: expected issue order,
// modes, timing and the integer dot product of the operand values.
module tb_vvp_seq;
  localparam int N = 64, MAXP = 8, A = 6, PB = 3, ACCW = 24;

  logic clk = 1'b0;
  logic rst, start, ws, ds, out_ready;
  logic [PB:0] wprec, dprec;
  logic busy0, busy3, ov0, ov3;
  logic [PB-1:0] wa0, da0, wa3, da3;
  logic [1:0] mode0, mode3;
  logic signed [ACCW-1:0] acc0, acc3;
  logic signed [A+1:0] s0, s3, s3_now;
  logic [2:0][A+1:0] dly;

  logic [N-1:0] wpl [MAXP];
  logic [N-1:0] dpl [MAXP];
  int Wv [N];
  int Dv [N];

  int nvec = 0, nmis = 0;
  int e = 0;
  int mst [2] = '{0, 0};
  int ks [2], jwp [2], jdp [2];
  bit jws [2], jds [2];
  longint esum [2], racc [2] = '{0, 0};
  int lat [2] = '{0, 3};
  logic [1:0] rec_mode [4];

  always #5 clk = ~clk;

  vvp_seq #(.N(N), .MAXP(MAXP), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .wprec(wprec), .dprec(dprec),
    .wsigned(ws), .dsigned(ds), .busy(busy0), .waddr(wa0), .daddr(da0),
    .mode(mode0), .s_in(s0), .acc_out(acc0), .out_valid(ov0),
    .out_ready(out_ready));

  vvp_seq #(.N(N), .MAXP(MAXP), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .wprec(wprec), .dprec(dprec),
    .wsigned(ws), .dsigned(ds), .busy(busy3), .waddr(wa3), .daddr(da3),
    .mode(mode3), .s_in(s3), .acc_out(acc3), .out_valid(ov3),
    .out_ready(out_ready));

  // Behavioural vvp: signed count of lanes where both plane bits are set.
  function automatic logic [A+1:0] vvp_f(input logic [1:0] m,
                                         input logic [N-1:0] w, d);
    int p, q;
    p = $countones(w & d);
    q = $countones(w & ~d);
    case (m)
      2'b01:   return (A+2)'(p);
      2'b11:   return (A+2)'(-p);
      2'b10:   return (A+2)'(p - q);
      default: return '0;
    endcase
  endfunction

  assign s0     = vvp_f(mode0, wpl[wa0], dpl[da0]);
  assign s3_now = vvp_f(mode3, wpl[wa3], dpl[da3]);
  assign s3     = dly[2];
  always @(posedge clk) begin
    dly[0] <= s3_now;
    dly[1] <= dly[0];
    dly[2] <= dly[1];
  end

  function automatic int cl(input int p);
    return (p == 0) ? 1 : (p > MAXP) ? MAXP : p;
  endfunction

  function automatic longint sval(input int v, input int p, input bit s);
    longint m;
    m = v & ((1 << p) - 1);
    if (s && v[p-1]) m = m - (longint'(1) << p);
    return m;
  endfunction

  function automatic longint dot(input int wp, dp, input bit sw, sd);
    longint acc = 0;
    for (int k = 0; k < N; k++) acc += sval(Wv[k], wp, sw) * sval(Dv[k], dp, sd);
    return acc;
  endfunction

  task automatic build_planes();
    for (int b = 0; b < MAXP; b++)
      for (int k = 0; k < N; k++) begin
        wpl[b][k] = Wv[k][b];
        dpl[b][k] = Dv[k][b];
      end
  endtask

  task automatic load(input int w, d);
    for (int k = 0; k < N; k++) begin Wv[k] = w; Dv[k] = d; end
    build_planes();
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++) begin
      Wv[k] = int'($urandom_range(255));
      Dv[k] = int'($urandom_range(255));
    end
    build_planes();
  endtask

  task automatic chk(input string nm, input int x, input longint act, exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s u%0d edge %0d: got %0d expected %0d", nm, x, e, act, exp);
    end
  endtask

  // Job-level model: which job each instance is in and where it should be.
  always @(posedge clk) begin
    e = e + 1;
    for (int x = 0; x < 2; x++) begin
      if (rst) begin
        mst[x] = 0; racc[x] = 0;
      end else begin
        case (mst[x])
          0: if (start) begin
            jwp[x] = cl(int'(wprec)); jdp[x] = cl(int'(dprec));
            jws[x] = ws; jds[x] = ds;
            esum[x] = dot(jwp[x], jdp[x], ws, ds);
            ks[x] = e; racc[x] = 0; mst[x] = 1;
          end
          1: if (e == ks[x] + jwp[x]*jdp[x] + lat[x]) begin
            mst[x] = 2; racc[x] = esum[x];
          end
          default: if (out_ready) mst[x] = 0;
        endcase
      end
    end
  end

  task automatic cmp(input int x, input logic b, v, input logic [PB-1:0] wa, da,
                     input logic [1:0] m, input logic signed [ACCW-1:0] ac);
    int off, i, j, em;
    chk("busy", x, b, longint'(mst[x] != 0));
    chk("out_valid", x, v, longint'(mst[x] == 2));
    if (mst[x] == 1) begin
      off = e - ks[x];
      if (off < jwp[x]*jdp[x]) begin
        i = off / jdp[x]; j = off % jdp[x];
        em = ((jws[x] && i == jwp[x]-1) ^ (jds[x] && j == jdp[x]-1)) ? 3 : 1;
        chk("waddr", x, wa, i);
        chk("daddr", x, da, j);
        chk("mode", x, m, em);
        if (off == 0) chk("acc_cleared", x, ac, 0);
      end else begin
        chk("mode_drain", x, m, 0);
        chk("waddr_drain", x, wa, 0);
      end
    end else begin
      chk("mode_idle", x, m, 0);
      chk("waddr_idle", x, wa, 0);
      chk("daddr_idle", x, da, 0);
      chk("acc_out", x, ac, racc[x]);
    end
  endtask

  always @(negedge clk) if (e > 0) begin
    cmp(0, busy0, ov0, wa0, da0, mode0, acc0);
    cmp(1, busy3, ov3, wa3, da3, mode3, acc3);
  end

  task automatic wait_both(output int t0, t3);
    t0 = -1; t3 = -1;
    for (int n = 1; n <= 400; n++) begin
      if (n <= 4) rec_mode[n-1] = mode0;
      if (ov0 && t0 < 0) t0 = n;
      if (ov3 && t3 < 0) t3 = n;
      if (t0 >= 0 && t3 >= 0) break;
      @(negedge clk);
    end
    if (t0 < 0 || t3 < 0) begin
      nvec++; nmis++;
      $display("FAIL timeout: out_valid u0 at %0d, u3 at %0d, required both", t0, t3);
    end
  endtask

  task automatic job(input int wp, dp, input bit sw, sd, input bit use_lit,
                     input longint lit, input int et0, et3);
    int t0, t3;
    wprec = 4'(wp); dprec = 4'(dp); ws = sw; ds = sd;
    out_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_both(t0, t3);
    if (t0 >= 0 && t3 >= 0) begin
      chk("first_valid", 0, t0, et0);
      chk("first_valid", 1, t3, et3);
      if (use_lit) begin
        chk("acc_lit", 0, acc0, lit);
        chk("acc_lit", 1, acc3, lit);
      end
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("idle_after_accept", 0, busy0, 0);
    chk("idle_after_accept", 1, busy3, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int em [4] = '{1, 3, 3, 1};
    int t0, t3;
    rst = 1'b1; start = 1'b0; wprec = 4'd1; dprec = 4'd1;
    ws = 1'b0; ds = 1'b0; out_ready = 1'b0;
    load(0, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, busy0, 0);
    chk("reset_valid", 1, ov3, 0);
    chk("reset_acc", 0, acc0, 0);
    chk("reset_mode", 1, mode3, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1x1 unsigned, all ones: 64, valid in cycle k+2 (k+5 with LAT=3)
    load(1, 1);
    job(1, 1, 0, 0, 1, 64, 2, 5);
    // 2x2 signed, W=-1 D=-1: modes 01,11,11,01 and +64
    load(-1, -1);
    job(2, 2, 1, 1, 1, 64, 5, 8);
    for (int q = 0; q < 4; q++) chk("mode_seq", 0, rec_mode[q], em[q]);
    // 2x2 signed, W=+1 D=-2: -128
    load(1, -2);
    job(2, 2, 1, 1, 1, -128, 5, 8);
    // 8x8 unsigned full scale: 64*255*255
    load(255, 255);
    job(8, 8, 0, 0, 1, 4161600, 65, 68);
    // clamping: wprec 0 -> 1, dprec 15 -> 8
    load(1, 255);
    job(0, 15, 0, 0, 1, 16320, 9, 12);
    // mixed-sign random operands, model only
    load_rand();
    job(3, 5, 1, 0, 0, 0, 16, 19);
    load_rand();
    job(4, 3, 0, 1, 0, 0, 13, 16);

    // out_ready high throughout: no effect before DONE
    load(1, 1);
    wprec = 4'd1; dprec = 4'd1; ws = 1'b0; ds = 1'b0;
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    chk("early_ready_acc", 0, acc0, 64);
    chk("early_ready_acc", 1, acc3, 64);

    // DONE stall with start pulses: 2x2 unsigned W=3 D=3 -> 576
    load(3, 3);
    wprec = 4'd2; dprec = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_both(t0, t3);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1 || c == 2);
      chk("stall_acc", 0, acc0, 576);
      chk("stall_acc", 1, acc3, 576);
      chk("stall_valid", 0, ov0, 1);
      chk("stall_valid", 1, ov3, 1);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("stall_release", 1, busy3, 0);
    chk("stall_release_valid", 0, ov0, 0);
    @(negedge clk);

    // reset on the 3rd ISSUE cycle, then an immediate fresh 1x1 job
    wprec = 4'd2; dprec = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", 1, busy3, 0);
    chk("rst_valid", 1, ov3, 0);
    chk("rst_acc", 0, acc0, 0);
    chk("rst_acc", 1, acc3, 0);
    job(1, 1, 0, 0, 1, 64, 2, 5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
